// File: rtl/stone_renderer.sv
// Per-frame stone sprite renderer: scans the stone RAM, erases each stone's previous
// 16x16 box from a shadow table and plots the current box to the pixel-write port.
module stone_renderer #(
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned SPRITE      = 16,
    parameter int unsigned SCREEN_W    = 320,
    parameter int unsigned SCREEN_H    = 240,
    parameter logic [2:0]  COL_BG      = 3'b000,
    parameter logic [2:0]  COL_STONE   = 3'b111,
    parameter logic [2:0]  COL_GOLD    = 3'b110,
    parameter logic [2:0]  COL_DIAMOND = 3'b011
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] ram_data,
    output logic [3:0]  draw_index,
    output logic        draw_stone_flag,
    output logic        plot,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  colour,
    output logic        done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_ERASE = 3'd3;
    localparam logic [2:0] S_DRAW  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [7:0] LAST_PIX  = 8'(SPRITE * SPRITE - 1);
    localparam logic [3:0] WAIT_LAST = 4'(RAM_LATENCY);

    logic [2:0]  state;
    logic [3:0]  q_lat;
    logic [3:0]  idx;
    logic [3:0]  wait_cnt;
    logic [7:0]  pix;
    logic [8:0]  cur_x;
    logic [7:0]  cur_y;
    logic [1:0]  cur_type;
    logic        vis;
    logic [8:0]  er_x;
    logic [7:0]  er_y;
    logic [15:0] shadow_valid;
    logic [16:0] shadow_xy [16];

    logic [8:0]  ram_x;
    logic [7:0]  ram_y;
    logic [1:0]  ram_type;
    logic        ram_vis;
    logic        erase_req;
    logic [3:0]  idx_inc;

    logic        unused_bits;

    assign ram_x    = ram_data[31:23];
    assign ram_y    = ram_data[18:11];
    assign ram_type = ram_data[3:2];
    assign ram_vis  = ram_data[1];
    assign unused_bits = ^{ram_data[22:19], ram_data[10:4], ram_data[0]};

    // A stone that is still visible at the same spot is redrawn without an erase pass.
    assign erase_req = shadow_valid[idx] & (~ram_vis | (shadow_xy[idx] != {ram_x, ram_y}));
    assign idx_inc   = idx + 4'd1;
    assign draw_index = idx;

    logic [8:0] base_x;
    logic [7:0] base_y;
    logic [2:0] pix_colour;
    logic [9:0] sum_x;
    logic [8:0] sum_y;
    logic       scanning;
    logic       on_screen;

    always_comb begin
        base_x     = cur_x;
        base_y     = cur_y;
        pix_colour = COL_DIAMOND;
        if (state == S_ERASE) begin
            base_x     = er_x;
            base_y     = er_y;
            pix_colour = COL_BG;
        end else if (cur_type == 2'd0) begin
            pix_colour = COL_STONE;
        end else if (cur_type == 2'd1) begin
            pix_colour = COL_GOLD;
        end
    end

    // Sums are one bit wider than the outputs so off-screen pixels can be clipped.
    assign sum_x     = {1'b0, base_x} + {6'd0, pix[3:0]};
    assign sum_y     = {1'b0, base_y} + {5'd0, pix[7:4]};
    assign scanning  = (state == S_ERASE) || (state == S_DRAW);
    assign on_screen = (sum_x < 10'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state           <= S_IDLE;
            q_lat           <= 4'd0;
            idx             <= 4'd0;
            wait_cnt        <= 4'd0;
            pix             <= 8'd0;
            cur_x           <= 9'd0;
            cur_y           <= 8'd0;
            cur_type        <= 2'd0;
            vis             <= 1'b0;
            er_x            <= 9'd0;
            er_y            <= 8'd0;
            shadow_valid    <= 16'd0;
            draw_stone_flag <= 1'b0;
            done            <= 1'b0;
            plot            <= 1'b0;
            x               <= 9'd0;
            y               <= 8'd0;
            colour          <= 3'd0;
        end else begin
            done <= 1'b0;
            plot <= scanning && on_screen;
            if (scanning && on_screen) begin
                x      <= sum_x[8:0];
                y      <= sum_y[7:0];
                colour <= pix_colour;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        q_lat           <= quantity;
                        idx             <= 4'd0;
                        wait_cnt        <= 4'd0;
                        draw_stone_flag <= 1'b1;
                        if (quantity != 4'd0) begin
                            state <= S_WAIT;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                // One cycle beyond the RAM latency covers the external address-mux switchover.
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 4'd0;
                        state    <= S_LATCH;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_LATCH: begin
                    cur_x    <= ram_x;
                    cur_y    <= ram_y;
                    cur_type <= ram_type;
                    vis      <= ram_vis;
                    er_x     <= shadow_xy[idx][16:8];
                    er_y     <= shadow_xy[idx][7:0];
                    pix      <= 8'd0;
                    if (erase_req)    state <= S_ERASE;
                    else if (ram_vis) state <= S_DRAW;
                    else              state <= S_NEXT;
                end
                S_ERASE: begin
                    pix <= pix + 8'd1;
                    if (pix == LAST_PIX) state <= vis ? S_DRAW : S_NEXT;
                end
                S_DRAW: begin
                    pix <= pix + 8'd1;
                    if (pix == LAST_PIX) state <= S_NEXT;
                end
                S_NEXT: begin
                    shadow_valid[idx] <= vis;
                    idx               <= idx_inc;
                    if (idx_inc == q_lat) begin
                        state           <= S_DONE;
                        done            <= 1'b1;
                        draw_stone_flag <= 1'b0;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    draw_stone_flag <= 1'b0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Shadow positions need no reset: they are only trusted when the matching valid bit is set.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_shadow
            always_ff @(posedge clock) begin
                if (state == S_NEXT && vis && idx == 4'(gi)) begin
                    shadow_xy[gi] <= {cur_x, cur_y};
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_stone_renderer.sv
// Testbench for stone_renderer: table-driven frames, hand-written corner sequences and
// randomized frames, all checked against a pixel-list model of the renderer.
module tb_stone_renderer;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [3:0]  quantity;
    logic [31:0] ram_data;
    logic [3:0]  draw_index;
    logic        draw_stone_flag;
    logic        plot;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        done;

    stone_renderer dut (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .quantity(quantity),
        .ram_data(ram_data),
        .draw_index(draw_index),
        .draw_stone_flag(draw_stone_flag),
        .plot(plot),
        .x(x),
        .y(y),
        .colour(colour),
        .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stone RAM with one cycle of read latency.
    logic [31:0] mem [16];
    always @(posedge clock) ram_data <= mem[draw_index];

    int n_checks;
    int n_err;

    // Reference model state: what the renderer should remember per index.
    int m_valid [16];
    int m_x [16];
    int m_y [16];
    int exp_q[$];
    int exp_cycles;

    // Observation window.
    int  cap[$];
    int  done_cnt;
    int  flag_cnt;
    bit  mon_en;
    int  got_cycles;

    always @(negedge clock) begin
        if (mon_en) begin
            if (plot) cap.push_back(int'(x) * 4096 + int'(y) * 8 + int'(colour));
            if (done) done_cnt++;
            if (draw_stone_flag) flag_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_square(input int bx, input int by, input int c);
        for (int r = 0; r < 16; r++) begin
            for (int cc = 0; cc < 16; cc++) begin
                if (bx + cc < 320 && by + r < 240)
                    exp_q.push_back((bx + cc) * 4096 + (by + r) * 8 + c);
            end
        end
    endtask

    task automatic build_expected(input int q);
        int wx, wy, wt, wv, col, er;
        exp_q.delete();
        exp_cycles = 2;
        for (int i = 0; i < q; i++) begin
            wx = int'(mem[i] >> 23) & 511;
            wy = int'(mem[i] >> 11) & 255;
            wt = int'(mem[i] >> 2) & 3;
            wv = int'(mem[i] >> 1) & 1;
            col = (wt == 0) ? 7 : (wt == 1) ? 6 : 3;
            er = (m_valid[i] != 0 && (wv == 0 || m_x[i] != wx || m_y[i] != wy)) ? 1 : 0;
            if (er != 0) push_square(m_x[i], m_y[i], 0);
            if (wv != 0) push_square(wx, wy, col);
            exp_cycles += 4 + 256 * er + 256 * wv;
            m_valid[i] = wv;
            if (wv != 0) begin
                m_x[i] = wx;
                m_y[i] = wy;
            end
        end
    endtask

    function automatic int bg_count();
        int n = 0;
        foreach (cap[k]) if ((cap[k] & 7) == 0) n++;
        return n;
    endfunction

    // Runs one frame of q entries and checks it against the model.
    task automatic run_frame(input string tag, input int q, input bit hold);
        int n, bad, lim;
        build_expected(q);
        cap.delete();
        done_cnt = 0;
        flag_cnt = 0;
        @(posedge clock); #1;
        quantity = 4'(q);
        start = 1'b1;
        mon_en = 1'b1;
        @(posedge clock); #1;
        n = 1;
        if (!hold) start = 1'b0;
        while (!done && n < 20000) begin
            @(posedge clock); #1;
            n++;
            if (hold && n == 200) start = 1'b0;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, int'(done), 1);
        got_cycles = n + 1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        mon_en = 1'b0;
        check({tag, "_cycles"}, got_cycles, exp_cycles);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_flag_cycles"}, flag_cnt, (q == 0) ? 1 : exp_cycles - 2);
        check({tag, "_flag_after"}, int'(draw_stone_flag), 0);
        check({tag, "_plot_count"}, cap.size(), exp_q.size());
        bad = -1;
        lim = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int k = 0; k < lim; k++) begin
            if (bad < 0 && cap[k] != exp_q[k]) bad = k;
        end
        check({tag, "_first_bad_pixel"}, bad, -1);
        $display("frame %s: q=%0d plots=%0d cycles=%0d", tag, q, cap.size(), got_cycles);
    endtask

    typedef struct {
        int q;
        int x0;
        int y0;
        int typ;
        int vm;
        int exp_plots;
        int exp_bg;
        int exp_cycles;
        int exp_flag;
    } vec_t;

    vec_t vecs [7];

    initial begin
        n_checks = 0;
        n_err    = 0;
        mon_en   = 1'b0;
        start    = 1'b0;
        quantity = 4'd0;
        resetn   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'd0;
            m_valid[i] = 0;
            m_x[i] = 0;
            m_y[i] = 0;
        end

        vecs[0] = '{1, 100, 50, 1, 2, 256, 0, 262, 260};
        vecs[1] = '{1, 100, 50, 1, 2, 256, 0, 262, 260};
        vecs[2] = '{1, 104, 60, 1, 2, 512, 256, 518, 516};
        vecs[3] = '{1, 104, 60, 1, 0, 256, 256, 262, 260};
        vecs[4] = '{1, 104, 60, 1, 0, 0, 0, 6, 4};
        vecs[5] = '{1, 310, 230, 0, 3, 100, 0, 262, 260};
        vecs[6] = '{0, 310, 230, 0, 3, 0, 0, 2, 1};

        repeat (3) @(posedge clock);
        #1;
        check("reset_plot", int'(plot), 0);
        check("reset_flag", int'(draw_stone_flag), 0);
        check("reset_done", int'(done), 0);
        check("reset_x", int'(x), 0);
        check("reset_colour", int'(colour), 0);
        resetn = 1'b1;

        for (int v = 0; v < 7; v++) begin
            mem[0] = (32'(vecs[v].x0) << 23) | (32'(vecs[v].y0) << 11)
                   | (32'(vecs[v].typ) << 2) | 32'(vecs[v].vm);
            run_frame($sformatf("tbl%0d", v), vecs[v].q, 1'b0);
            check($sformatf("tbl%0d_plots", v), cap.size(), vecs[v].exp_plots);
            check($sformatf("tbl%0d_bg", v), bg_count(), vecs[v].exp_bg);
            check($sformatf("tbl%0d_cyc", v), got_cycles, vecs[v].exp_cycles);
            check($sformatf("tbl%0d_flag", v), flag_cnt, vecs[v].exp_flag);
            if (v == 0 && cap.size() == 256) begin
                check("tbl0_first_pixel", cap[0], 100 * 4096 + 50 * 8 + 6);
                check("tbl0_row1_pixel", cap[16], 100 * 4096 + 51 * 8 + 6);
                check("tbl0_last_pixel", cap[255], 115 * 4096 + 65 * 8 + 6);
            end
        end

        // start held high for most of a scan must not retrigger the frame.
        run_frame("hold_start", 1, 1'b1);

        // Reset in the middle of DRAW, then the same data must draw without an erase.
        mem[0] = (32'd20 << 23) | (32'd20 << 11) | (32'd2 << 2) | 32'd2;
        run_frame("pre_reset", 1, 1'b0);
        @(posedge clock); #1;
        quantity = 4'd1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (100) @(posedge clock);
        #2;
        check("mid_draw_was_plotting", int'(plot), 1);
        resetn = 1'b0;
        #1;
        check("rst_plot", int'(plot), 0);
        check("rst_flag", int'(draw_stone_flag), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_index", int'(draw_index), 0);
        @(posedge clock); #1;
        check("rst_done", int'(done), 0);
        resetn = 1'b1;
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        run_frame("post_reset", 1, 1'b0);
        check("post_reset_bg", bg_count(), 0);
        check("post_reset_plots", cap.size(), 256);

        // Randomized frames: a mix of unchanged, moved, hidden and new stones.
        for (int f = 0; f < 5; f++) begin
            int q;
            q = $urandom_range(0, 10);
            for (int i = 0; i < q; i++) begin
                if ($urandom_range(0, 3) != 0) mem[i] = $urandom();
            end
            run_frame($sformatf("rnd%0d", f), q, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/stone_renderer.md
Name: stone_renderer

Overview:
- Read-side counterpart of the rope/stone RAM controller.
- Once per frame, takes ownership of the shared stone RAM read port by raising draw_stone_flag, then scans entries 0..quantity-1.
- For each entry it erases the stone's previously drawn 16x16 box and plots the current box into the VGA pixel-write interface.
- A per-index shadow table of last-drawn positions lets moving or collected stones disappear cleanly.

Parameters:
- RAM_LATENCY, 1, cycles from draw_index stable to ram_data valid.
- SPRITE, 16, square sprite edge in pixels; fixed at 16, counter is 8 bits.
- SCREEN_W, 320, pixels with x >= SCREEN_W are not plotted.
- SCREEN_H, 240, pixels with y >= SCREEN_H are not plotted.
- COL_BG, 3'b000, erase colour.
- COL_STONE, 3'b111, colour for type 0.
- COL_GOLD, 3'b110, colour for type 1.
- COL_DIAMOND, 3'b011, colour for types 2 and 3.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  frame pulse; accepted only in IDLE.
- quantity  in  4  number of valid RAM entries; latched at start.
- ram_data  in  32  stone RAM q. Fields: [31:23] X, [18:11] Y, [3:2] type, [1] visible, [0] moving.
- draw_index  out  4  RAM read address while draw_stone_flag=1.
- draw_stone_flag  out  1  high for the whole scan; RAM owners must not write while it is high.
- plot  out  1  pixel write strobe.
- x  out  9  pixel x.
- y  out  8  pixel y.
- colour  out  3  pixel colour.
- done  out  1  one-cycle pulse at the end of the scan.

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs 0. idx=0, pix=0. All 16 shadow_valid bits cleared. Takes effect immediately, including mid-scan; no done pulse is generated.
- States: IDLE, WAIT, LATCH, ERASE, DRAW, NEXT, DONE.
- IDLE:
  - start=1 -> latch quantity as q_lat, idx=0, draw_stone_flag=1.
  - Next state is WAIT if q_lat!=0, else DONE.
- WAIT:
  - draw_index=idx.
  - Hold RAM_LATENCY+1 cycles; the extra cycle covers the external address-mux switchover.
  - Then go to LATCH.
- LATCH:
  - Register cur_x=ram_data[31:23], cur_y=ram_data[18:11], type, vis=ram_data[1].
  - erase_req = shadow_valid[idx] & (!vis | shadow_xy[idx] != {cur_x,cur_y}).
  - Next state is ERASE if erase_req, else DRAW if vis, else NEXT.
- ERASE:
  - 256 cycles, pix=0..255, col=pix[3:0], row=pix[7:4].
  - Pixel position = shadow x + col, shadow y + row; colour=COL_BG.
  - After pix=255: go to DRAW if vis, else NEXT.
- DRAW:
  - 256 cycles, same scan order, at cur_x+col, cur_y+row.
  - colour by type: 0->COL_STONE, 1->COL_GOLD, 2/3->COL_DIAMOND.
  - After pix=255: go to NEXT.
- NEXT (1 cycle):
  - If vis: shadow_xy[idx]={cur_x,cur_y}, shadow_valid[idx]=1.
  - Else: shadow_valid[idx]=0.
  - idx+1; if idx+1 == q_lat go to DONE, else WAIT.
- DONE (1 cycle): done=1, draw_stone_flag=0, then IDLE.
- draw_stone_flag is high from the cycle after start acceptance through the last NEXT cycle. In the quantity=0 case it is high for exactly 1 cycle (the DONE-entry cycle).
- Pixel arithmetic and clipping:
  - x sum is computed in 10 bits, y sum in 9 bits.
  - plot=1 only if the sum is < SCREEN_W / SCREEN_H; otherwise plot=0 but pix still advances.
  - x/y outputs are the low 9/8 bits of the sums.
  - x, y, colour are registered and change only when plot is valid or in IDLE (hold values).
- Per-entry cycle count: RAM_LATENCY+2 + 256*erase_req + 256*vis + 1.
- start while busy: ignored.
- Entries >= q_lat: shadow untouched.
- An unchanged visible stone is redrawn without erase, so no flicker.

Test Plan:
- Visible stone at X=100,Y=50,type1, quantity=1, start:
  - Flag high; exactly 256 plots, colour 3'b110, x 100..115, y 50..65, row-major.
  - Then done pulse, flag low.
  - Total cycles start->done = 1+RAM_LATENCY+2+256+1+1.
- Same frame repeated unchanged -> 256 draw plots only, no COL_BG plots.
- Entry moved to X=104,Y=60 -> 256 COL_BG plots at 100..115/50..65, then 256 plots at 104..119/60..75.
- Entry bits[1:0]=00 after having been drawn -> 256 COL_BG plots, no draw. Next frame: zero plots for that index.
- Stone at X=310,Y=230 -> only 10x10=100 plot pulses; pix still runs 256 cycles.
- quantity=0 -> flag high 1 cycle, done pulse, zero plots.
- Reset asserted mid-DRAW -> outputs 0 immediately. Next frame with same data draws without erase, since shadow was cleared.
- start held during a scan -> ignored, single done pulse.
